snake_body_resp: RTL

//   Snake game-state responder for the VGA scan. The display controller drives the

---
 rtl/snake_body_resp.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/snake_body_resp.sv
// ---------------------------------------------------------------------------
// snake_body_resp : per-player snake body, move/turn FSM, growth, collision
//                   and registered VGA pixel classification.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snake_body_resp #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 10,
  parameter int START_Y  = 5,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic [3:0] dir_key,
  input  logic       add_cube,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [1:0] snake,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] length,
  output logic       hit_flag
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_e;
  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_e;

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d, next_dir_q, next_dir_d;
  logic [5:0] seg_x_q [MAX_LEN];
  logic [5:0] seg_y_q [MAX_LEN];
  logic [5:0] seg_x_d [MAX_LEN];
  logic [5:0] seg_y_d [MAX_LEN];
  logic [4:0] length_q, length_d;
  logic       grow_pending_q, grow_pending_d;
  logic       hit_flag_q, hit_flag_d;
  logic [1:0] snake_q, snake_d;

  dir_e       key_dir, next_dir_c;
  logic       key_valid;
  logic [5:0] new_x, new_y;
  logic       grow, wall_hit, body_hit;
  logic [5:0] cx, cy;

  always_comb begin
    key_dir   = dir_q;
    key_valid = 1'b1;
    if      (dir_key[3]) key_dir = D_UP;
    else if (dir_key[2]) key_dir = D_DOWN;
    else if (dir_key[1]) key_dir = D_LEFT;
    else if (dir_key[0]) key_dir = D_RIGHT;
    else                 key_valid = 1'b0;
    if (key_valid && key_dir != dir_e'({dir_q[1], ~dir_q[0]}))
      next_dir_c = key_dir;
    else
      next_dir_c = next_dir_q;
  end

  // A turn taken on a move tick steers that same move.
  always_comb begin
    new_x = seg_x_q[0];
    new_y = seg_y_q[0];
    case (next_dir_c)
      D_UP:    new_y = seg_y_q[0] - 6'd1;
      D_DOWN:  new_y = seg_y_q[0] + 6'd1;
      D_LEFT:  new_x = seg_x_q[0] - 6'd1;
      default: new_x = seg_x_q[0] + 6'd1;
    endcase
    grow     = grow_pending_q | add_cube;
    wall_hit = (new_x == 6'd0) || (new_x == 6'(GRID_W - 1)) ||
               (new_y == 6'd0) || (new_y == 6'(GRID_H - 1));
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(length_q) - 1 || (grow && i == int'(length_q) - 1)) &&
          seg_x_q[i] == new_x && seg_y_q[i] == new_y)
        body_hit = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    next_dir_d     = next_dir_q;
    seg_x_d        = seg_x_q;
    seg_y_d        = seg_y_q;
    length_d       = length_q;
    grow_pending_d = grow_pending_q;
    hit_flag_d     = hit_flag_q;
    case (state_q)
      S_IDLE: begin
        next_dir_d     = next_dir_c;
        grow_pending_d = grow;
        if (|dir_key) state_d = S_RUN;
      end
      S_RUN: begin
        next_dir_d     = next_dir_c;
        grow_pending_d = grow;
        if (move_tick) begin
          dir_d = next_dir_c;
          if (wall_hit || body_hit) begin
            state_d    = S_DEAD;
            hit_flag_d = 1'b1;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0]     = new_x;
            seg_y_d[0]     = new_y;
            grow_pending_d = 1'b0;
            if (grow && length_q < 5'(MAX_LEN)) length_d = length_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cx      = x_pos[9:4];
    cy      = y_pos[9:4];
    snake_d = 2'b00;
    if (x_pos < 10'd640 && y_pos < 10'd480) begin
      if (seg_x_q[0] == cx && seg_y_q[0] == cy) begin
        snake_d = 2'b01;
      end else begin
        for (int i = 1; i < MAX_LEN; i++) begin
          if (i < int'(length_q) && seg_x_q[i] == cx && seg_y_q[i] == cy)
            snake_d = 2'b10;
        end
        if (snake_d == 2'b00 &&
            (cx == 6'd0 || cx == 6'(GRID_W - 1) || cy == 6'd0 || cy == 6'(GRID_H - 1)))
          snake_d = 2'b11;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      dir_q          <= D_RIGHT;
      next_dir_q     <= D_RIGHT;
      length_q       <= 5'(INIT_LEN);
      grow_pending_q <= 1'b0;
      hit_flag_q     <= 1'b0;
      snake_q        <= 2'b00;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? 6'(START_X - i) : 6'(START_X - INIT_LEN + 1);
        seg_y_q[i] <= 6'(START_Y);
      end
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      next_dir_q     <= next_dir_d;
      length_q       <= length_d;
      grow_pending_q <= grow_pending_d;
      hit_flag_q     <= hit_flag_d;
      snake_q        <= snake_d;
      seg_x_q        <= seg_x_d;
      seg_y_q        <= seg_y_d;
    end
  end

  assign snake    = snake_q;
  assign head_x   = seg_x_q[0];
  assign head_y   = seg_y_q[0];
  assign length   = length_q;
  assign hit_flag = hit_flag_q;

endmodule

`default_nettype wire
